// File: rtl/tl_ul_sram_slave.sv
// Single-beat TileLink-UL slave backed by a 64-bit synchronous scratchpad, one request in flight.
// Optional per-word poison tracking is enabled by defining TL_UL_SRAM_POISON_EN.
module tl_ul_sram_slave #(
    parameter int ADDR_BITS   = 14,
    parameter int SOURCE_BITS = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [2:0]             a_opcode,
    input  logic [2:0]             a_param,
    input  logic [3:0]             a_size,
    input  logic [SOURCE_BITS-1:0] a_source,
    input  logic [ADDR_BITS-1:0]   a_address,
    input  logic [7:0]             a_mask,
    input  logic [63:0]            a_data,
    input  logic                   a_corrupt,
    output logic                   d_valid,
    input  logic                   d_ready,
    output logic [2:0]             d_opcode,
    output logic [1:0]             d_param,
    output logic [3:0]             d_size,
    output logic [SOURCE_BITS-1:0] d_source,
    output logic                   d_denied,
    output logic [63:0]            d_data,
    output logic                   d_corrupt
);
    localparam int WORDS = 1 << (ADDR_BITS - 3);

    typedef enum logic {IDLE, RESP} state_t;
    state_t state;

    logic [63:0]          mem [WORDS];
    logic [ADDR_BITS-4:0] idx;
    logic [2:0]           align_mask;
    logic                 legal, accept, wr_en, rd_poison;
    logic                 is_get, is_put, is_hint, is_atomic, is_reserved;

    always_comb begin
        align_mask = 3'b000;
        case (a_size)
            4'd1:    align_mask = 3'b001;
            4'd2:    align_mask = 3'b011;
            4'd3:    align_mask = 3'b111;
            default: align_mask = 3'b000;
        endcase
    end

    assign idx         = a_address[ADDR_BITS-1:3];
    assign legal       = (a_size <= 4'd3) && ((a_address[2:0] & align_mask) == 3'b000);
    assign is_get      = (a_opcode == 3'd4);
    assign is_put      = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    assign is_hint     = (a_opcode == 3'd5);
    assign is_atomic   = (a_opcode == 3'd2) || (a_opcode == 3'd3);
    assign is_reserved = (a_opcode[2:1] == 2'b11);

    // Combinational through d_ready so a held response and a new accept share one edge.
    assign a_ready = (state == IDLE) || d_ready;
    assign accept  = a_valid && a_ready;
    assign wr_en   = accept && legal && is_put;
    assign d_param = 2'b00;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
            end
        end
    end

`ifdef TL_UL_SRAM_POISON_EN
    logic [WORDS-1:0] poison;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            poison <= '0;
        end else if (wr_en && (a_mask != 8'h00)) begin
            poison[idx] <= a_corrupt;
        end
    end

    assign rd_poison = poison[idx];

    logic unused_inputs;
    assign unused_inputs = ^a_param;
`else
    assign rd_poison = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{a_param, a_corrupt};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            d_valid   <= 1'b0;
            d_opcode  <= 3'd0;
            d_size    <= 4'd0;
            d_source  <= '0;
            d_denied  <= 1'b0;
            d_data    <= 64'd0;
            d_corrupt <= 1'b0;
        end else if (accept) begin
            state    <= RESP;
            d_valid  <= 1'b1;
            d_size   <= a_size;
            d_source <= a_source;
            if (is_atomic) begin
                d_opcode  <= 3'd1;
                d_denied  <= 1'b1;
                d_corrupt <= 1'b1;
                d_data    <= 64'd0;
            end else if (!legal || is_reserved) begin
                // Denied responses keep the Get/non-Get distinction in the ack type.
                d_opcode  <= {2'b00, is_get};
                d_denied  <= 1'b1;
                d_corrupt <= is_get;
                d_data    <= 64'd0;
            end else if (is_get) begin
                d_opcode  <= 3'd1;
                d_denied  <= 1'b0;
                d_corrupt <= rd_poison;
                d_data    <= mem[idx];
            end else if (is_hint) begin
                d_opcode  <= 3'd2;
                d_denied  <= 1'b0;
                d_corrupt <= 1'b0;
                d_data    <= 64'd0;
            end else begin
                d_opcode  <= 3'd0;
                d_denied  <= 1'b0;
                d_corrupt <= 1'b0;
                d_data    <= 64'd0;
            end
        end else if (d_ready) begin
            state   <= IDLE;
            d_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tl_ul_sram_slave.sv
// Scoreboard bench for tl_ul_sram_slave: a reference model predicts each D beat at accept time.
// Poison expectations follow TL_UL_SRAM_POISON_EN when it is defined for the build.
module tb_tl_ul_sram_slave;
    localparam int AB = 14;
    localparam int SB = 8;
    localparam int RW = 83;

    logic          clock = 1'b0;
    logic          reset;
    logic          a_valid, a_ready;
    logic [2:0]    a_opcode, a_param;
    logic [3:0]    a_size;
    logic [SB-1:0] a_source;
    logic [AB-1:0] a_address;
    logic [7:0]    a_mask;
    logic [63:0]   a_data;
    logic          a_corrupt;
    logic          d_valid, d_ready;
    logic [2:0]    d_opcode;
    logic [1:0]    d_param;
    logic [3:0]    d_size;
    logic [SB-1:0] d_source;
    logic          d_denied;
    logic [63:0]   d_data;
    logic          d_corrupt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;
    logic [RW-1:0] exp_q[$];
    int beat_cyc[$];
    logic [63:0] mem_m [2048];
    logic        pois_m [2048];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    tl_ul_sram_slave #(.ADDR_BITS(AB), .SOURCE_BITS(SB)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data), .a_corrupt(a_corrupt),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
        .d_corrupt(d_corrupt)
    );

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] pack_resp(input logic [2:0] op, input logic [3:0] size,
                                                input logic [7:0] src, input logic den,
                                                input logic cor, input logic [63:0] data);
        return {2'b00, op, size, src, den, cor, data};
    endfunction

    function automatic logic [RW-1:0] d_vec();
        return {d_param, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data};
    endfunction

    // Reference behaviour of one accepted request; updates the memory/poison model.
    task automatic model_req(input logic [2:0] op, input logic [3:0] size, input logic [7:0] src,
                             input logic [13:0] addr, input logic [7:0] mask,
                             input logic [63:0] data, input logic cor);
        logic [10:0] idx;
        logic        lg;
        idx = addr[13:3];
        lg  = (size <= 4'd3) && ((int'(addr[2:0]) % (1 << int'(size[1:0]))) == 0);
        if (op == 3'd2 || op == 3'd3) begin
            exp_q.push_back(pack_resp(3'd1, size, src, 1'b1, 1'b1, 64'd0));
        end else if (!lg || op >= 3'd6) begin
            exp_q.push_back(pack_resp((op == 3'd4) ? 3'd1 : 3'd0, size, src, 1'b1,
                                      op == 3'd4, 64'd0));
        end else if (op == 3'd4) begin
`ifdef TL_UL_SRAM_POISON_EN
            exp_q.push_back(pack_resp(3'd1, size, src, 1'b0, pois_m[idx], mem_m[idx]));
`else
            exp_q.push_back(pack_resp(3'd1, size, src, 1'b0, 1'b0, mem_m[idx]));
`endif
        end else if (op == 3'd5) begin
            exp_q.push_back(pack_resp(3'd2, size, src, 1'b0, 1'b0, 64'd0));
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) mem_m[idx][8*i +: 8] = data[8*i +: 8];
            end
            if (mask != 8'h00) pois_m[idx] = cor;
            exp_q.push_back(pack_resp(3'd0, size, src, 1'b0, 1'b0, 64'd0));
        end
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [3:0] size, input logic [7:0] src,
                           input logic [13:0] addr, input logic [7:0] mask,
                           input logic [63:0] data, input logic cor);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_param   = 3'($urandom_range(0, 7));
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = cor;
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] size, input logic [7:0] src,
                        input logic [13:0] addr, input logic [7:0] mask,
                        input logic [63:0] data, input logic cor);
        int n;
        n = 0;
        @(negedge clock);
        if (rand_ready) d_ready = ($urandom_range(0, 3) != 0);
        drive_a(op, size, src, addr, mask, data, cor);
        #1;
        while (!a_ready && n < 100) begin
            @(negedge clock);
            if (rand_ready) d_ready = ($urandom_range(0, 3) != 0);
            #1;
            n++;
        end
        if (!a_ready) check("accept_timeout", RW'(n), RW'(0));
        else model_req(op, size, src, addr, mask, data, cor);
    endtask

    task automatic idle();
        @(negedge clock);
        a_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        d_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        #4;
        check("drain", RW'(exp_q.size()), RW'(0));
    endtask

    // Monitor samples 2 time units before the rising edge.
    always @(negedge clock) begin
        #3;
        if (!reset && d_valid && d_ready) begin
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("unexpected_beat", RW'(exp_q.size()), RW'(1));
            else check("d_beat", d_vec(), exp_q.pop_front());
        end
    end

    initial begin
        int base;
        reset   = 1'b1;
        a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0;
        d_ready = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            pois_m[i] = 1'b0;
            mem_m[i]  = 64'd0;
        end

        repeat (2) @(negedge clock);
        #3;
        check("rst_d_valid", RW'(d_valid), RW'(0));
        check("rst_d_fields", d_vec(), RW'(0));
        check("rst_a_ready_idle", RW'(a_ready), RW'(1));
        @(negedge clock);
        reset   = 1'b0;
        d_ready = 1'b1;

        // Full put then read back, then partial overwrite of the low lanes.
        send(3'd0, 4'd3, 8'h12, 14'h0040, 8'hFF, 64'h1122334455667788, 1'b0);
        send(3'd4, 4'd3, 8'h13, 14'h0040, 8'h00, 64'd0, 1'b0);
        send(3'd1, 4'd3, 8'h14, 14'h0040, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0);
        send(3'd4, 4'd3, 8'h15, 14'h0040, 8'h00, 64'd0, 1'b0);
        idle();
        drain();

        // Denials, hint, atomics, odd sizes; each followed by reads proving memory state.
        send(3'd4, 4'd3, 8'h16, 14'h0044, 8'hFF, 64'd0, 1'b0);
        send(3'd4, 4'd3, 8'h17, 14'h0040, 8'hFF, 64'd0, 1'b0);
        send(3'd2, 4'd3, 8'h20, 14'h0040, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b0);
        send(3'd3, 4'd3, 8'h21, 14'h0040, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b0);
        send(3'd6, 4'd3, 8'h22, 14'h0040, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b0);
        send(3'd7, 4'd3, 8'h23, 14'h0040, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b0);
        send(3'd5, 4'd3, 8'h24, 14'h0040, 8'h00, 64'd0, 1'b0);
        send(3'd0, 4'd4, 8'h25, 14'h0040, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b0);
        send(3'd1, 4'd1, 8'h26, 14'h0041, 8'h06, 64'hDEADBEEFDEADBEEF, 1'b0);
        send(3'd4, 4'd2, 8'h27, 14'h0042, 8'h00, 64'd0, 1'b0);
        send(3'd0, 4'd0, 8'h28, 14'h0043, 8'h08, 64'h00000000_5A000000, 1'b0);
        send(3'd4, 4'd2, 8'h29, 14'h0044, 8'h00, 64'd0, 1'b0);
        idle();
        drain();

        // Backpressure: response held while a second request waits.
        d_ready = 1'b0;
        send(3'd4, 4'd3, 8'h30, 14'h0040, 8'h00, 64'd0, 1'b0);
        @(negedge clock);
        drive_a(3'd4, 4'd3, 8'h31, 14'h0040, 8'h00, 64'd0, 1'b0);
        repeat (5) begin
            @(negedge clock);
            #3;
            check("bp_a_ready", RW'(a_ready), RW'(0));
            check("bp_d_hold", d_vec(), exp_q[0]);
            check("bp_d_valid", RW'(d_valid), RW'(1));
        end
        @(negedge clock);
        d_ready = 1'b1;
        base = beat_cyc.size();
        #1;
        check("bp_release", RW'(a_ready), RW'(1));
        model_req(3'd4, 4'd3, 8'h31, 14'h0040, 8'h00, 64'd0, 1'b0);
        send(3'd4, 4'd3, 8'h32, 14'h0040, 8'h00, 64'd0, 1'b0);
        send(3'd4, 4'd3, 8'h33, 14'h0044, 8'h00, 64'd0, 1'b0);
        send(3'd4, 4'd3, 8'h34, 14'h0040, 8'h00, 64'd0, 1'b0);
        idle();
        drain();
        check("bp_beat_count", RW'(beat_cyc.size() - base), RW'(5));
        for (int i = base + 1; i < base + 5 && i < beat_cyc.size(); i++) begin
            check("bp_back_to_back", RW'(beat_cyc[i] - beat_cyc[i-1]), RW'(1));
        end

        // Asynchronous reset with a response pending.
        d_ready = 1'b0;
        send(3'd4, 4'd3, 8'h40, 14'h0040, 8'h00, 64'd0, 1'b0);
        idle();
        #3;
        check("pre_rst_valid", RW'(d_valid), RW'(1));
        #1;
        reset = 1'b1;
        #1;
        check("rst_async_drop", RW'(d_valid), RW'(0));
        exp_q.delete();
        for (int i = 0; i < 2048; i++) pois_m[i] = 1'b0;
        base = beat_cyc.size();
        @(negedge clock);
        reset   = 1'b0;
        d_ready = 1'b1;
        repeat (4) @(negedge clock);
        #3;
        check("no_stale_beat", RW'(beat_cyc.size() - base), RW'(0));
        check("post_rst_valid", RW'(d_valid), RW'(0));
        send(3'd4, 4'd3, 8'h41, 14'h0040, 8'h00, 64'd0, 1'b0);

        // Poison round trip; corrupt stays 0 unless poison storage is built in.
        send(3'd0, 4'd3, 8'h50, 14'h0100, 8'hFF, 64'h0123456789ABCDEF, 1'b1);
        send(3'd4, 4'd3, 8'h51, 14'h0100, 8'h00, 64'd0, 1'b0);
        send(3'd0, 4'd3, 8'h52, 14'h0100, 8'hFF, 64'hFEDCBA9876543210, 1'b0);
        send(3'd4, 4'd3, 8'h53, 14'h0100, 8'h00, 64'd0, 1'b0);
        idle();
        drain();

        // Randomised traffic over 16 preloaded words with random D backpressure.
        for (int w = 0; w < 16; w++) begin
            send(3'd0, 4'd3, 8'(w), 14'(w * 8), 8'hFF, {$urandom, $urandom}, 1'b0);
        end
        rand_ready = 1'b1;
        repeat (200) begin
            send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 4)), 8'($urandom_range(0, 255)),
                 14'(($urandom_range(0, 15) << 3) | $urandom_range(0, 7)),
                 8'($urandom_range(0, 255)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
